obi_master: RTL and testbench
=============================

// Module: obi_master
// PURPOSE
//  OBI manager (initiator) front-end: takes one-shot read/write commands from a local
//  controller, drives the OBI A channel to an obi_slave-style subordinate, collects the
//  R-channel response and hands data/error back to the controller.
//  Single outstanding transaction. Optional watchdog aborts stalled accesses.
// PARAMETERS
//  ADDR_WIDTH      32   OBI address width
//  DATA_WIDTH      32   OBI data width; must be a multiple of 8
//  TIMEOUT_CYCLES  16   watchdog limit per phase in cycles; 0 disables the watchdog
// PORTS
//  clk_i           in   1            clock, rising edge
//  reset_ni        in   1            asynchronous, active-low reset
//  ctrl_valid_i    in   1            controller command valid
//  ctrl_ready_o    out  1            command accepted when valid&ready
//  ctrl_we_i       in   1            1 = write, 0 = read
//  ctrl_addr_i     in   ADDR_WIDTH   command address
//  ctrl_wdata_i    in   DATA_WIDTH   write data
//  ctrl_be_i       in   DATA_WIDTH/8 byte enables
//  ctrl_rvalid_o   out  1            response valid; held until ctrl_rready_i
//  ctrl_rready_i   in   1            controller response ready
//  ctrl_rdata_o    out  DATA_WIDTH   read data; undefined for writes
//  ctrl_err_o      out  1            slave error or timeout
//  obi_req_o       out  1            A-channel request
//  obi_gnt_i       in   1            A-channel grant
//  obi_addr_o      out  ADDR_WIDTH   A-channel address
//  obi_we_o        out  1            A-channel write enable
//  obi_be_o        out  DATA_WIDTH/8 A-channel byte enables
//  obi_wdata_o     out  DATA_WIDTH   A-channel write data
//  obi_rvalid_i    in   1            R-channel valid
//  obi_rready_o    out  1            R-channel ready
//  obi_rdata_i     in   DATA_WIDTH   R-channel read data
//  obi_err_i       in   1            R-channel error
// BEHAVIOUR
//  Reset (async, reset_ni=0): state=IDLE, every output 0, ctrl_ready_o=0, watchdog=0.
//  All outputs are registered; no input-to-output combinational path.
//  IDLE (2'b00): ctrl_ready_o=1. On valid&ready, latch addr/we/be/wdata into the A regs.
//    The next edge sets obi_req_o=1 and moves to ADDR.
//  ADDR: hold req/addr/we/be/wdata stable until the edge where obi_gnt_i=1.
//    At that edge: req=0, rready=1, go to RESP. This gives one A-phase cycle minimum.
//  RESP: obi_rready_o=1. On the edge where rvalid=1, capture rdata and err.
//    Then set rready=0, ctrl_rvalid_o=1, and go to HOLD.
//  HOLD: ctrl_rvalid_o, ctrl_rdata_o and ctrl_err_o stay stable until ctrl_rready_i=1.
//    Then ctrl_rvalid_o=0, ctrl_ready_o=1, return to IDLE.
//  Best-case latency: command accept -> ctrl_rvalid_o is 3 cycles with gnt and rvalid
//    both immediate. No back-to-back pipelining.
//  Watchdog: counts cycles spent in ADDR or RESP and resets to 0 on every state change.
//    When it reaches TIMEOUT_CYCLES, drop req and rready.
//    Then ctrl_rdata_o=TIMEOUT_RDATA, ctrl_err_o=1, go to HOLD.
//    Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates.
//  Abort in ADDR is a recovery deviation from OBI (req withdrawn without gnt).
//    It is documented and counted as an error.
//  A gnt and a timeout on the same edge: the gnt wins. Likewise rvalid beats a timeout.
//  rvalid arriving in IDLE, ADDR or HOLD is ignored. Commands arriving outside IDLE
//    are not accepted (ready=0).
//  Reset mid-transaction: outputs return to 0 and state to IDLE immediately.
//    The in-flight response is dropped.
// STRUCTURE
//  obi_pkg holds the shared items:
//    typedef enum logic[1:0] {IDLE=2'b00, ADDR, RESP, HOLD} obi_mgr_state_e
//    localparam TIMEOUT_RDATA = 32'hDEAD_BEEF
//    localparam BAD_RDATA = 32'hBADC_AB1E, shared with obi_slave
//  Sub-module obi_watchdog: saturating counter with clear and expire outputs.
//  The FSM and data registers stay in obi_master.
// TESTING (bench instantiates obi_master connected to obi_slave preloaded from mem.hex)
//  T0 reset pulse mid-run -> state==IDLE, all outputs 0, then ctrl_ready_o=1.
//  T1 read 0x0000_0004 -> ctrl_rvalid_o within 3 cycles, rdata=DA7A_5EAD, err=0.
//  T2 read 0xFFFF_FFFF -> rdata=BADC_AB1E, err=1.
//  T3 write 0x0000_0002 data 1337_C0DE be=4'hF -> dut mem[2]==1337_C0DE.
//    Read back of 0x2 returns 1337_C0DE.
//  T4 stub slave grants after 3 cycles -> req and addr stable for all 4 A cycles.
//    Response correct. Hold ctrl_rready_i=0 for 5 cycles -> response stays stable.
//  T5 stub slave never asserts rvalid, TIMEOUT_CYCLES=16 -> after 16 RESP cycles:
//    err=1, rdata=DEAD_BEEF, then a clean return to IDLE.

Source files
------------

// File: rtl/obi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : obi_pkg
//  Description : Shared types and constants for the OBI manager front-end
//                and its companion subordinate.
//  Revision    : 1.0  initial release
// ============================================================================
package obi_pkg;

    // Manager FSM encoding; IDLE must stay 2'b00 so reset decodes as idle.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        RESP = 2'b10,
        HOLD = 2'b11
    } obi_mgr_state_e;

    // Read data returned to the controller when the watchdog aborts an access.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Read data a subordinate returns for an unmapped address.
    localparam logic [31:0] BAD_RDATA = 32'hBADC_AB1E;

endpackage
`default_nettype wire

// File: rtl/obi_if.sv
`default_nettype none
// ============================================================================
//  Module      : obi_if
//  Description : OBI A/R channel bundle with manager and subordinate views.
//  Revision    : 1.0  initial release
// ============================================================================
interface obi_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      req;
    logic                      gnt;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      rvalid;
    logic                      rready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      err;

    modport master (
        output req, addr, we, be, wdata, rready,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, be, wdata, rready,
        output gnt, rvalid, rdata, err
    );
endinterface
`default_nettype wire

// File: rtl/obi_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : obi_watchdog
//  Description : Saturating per-phase cycle counter. Raises expire_o during
//                the LIMIT-th consecutive cycle spent in ADDR or RESP; the
//                count restarts whenever the observed state changes.
//                LIMIT = 0 disables the watchdog entirely.
//  Revision    : 1.0  initial release
// ============================================================================
module obi_watchdog
    import obi_pkg::*;
#(
    parameter int unsigned LIMIT = 16
) (
    input  wire logic           clk_i,
    input  wire logic           reset_ni,
    input  wire obi_mgr_state_e state_i,
    output logic                expire_o
);

    localparam int unsigned CNT_W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam int unsigned EXT_W = CNT_W + 1;

    generate
        if (LIMIT > 0) begin : g_enabled
            localparam logic [EXT_W-1:0] C_LIMIT = EXT_W'(LIMIT);

            logic [CNT_W-1:0] r_count;      // completed cycles in current phase
            obi_mgr_state_e   r_state_seen; // state observed on the previous cycle
            logic             w_active;
            logic             w_changed;
            logic [EXT_W-1:0] w_cycles;     // cycles in phase including this one

            assign w_active  = (state_i == ADDR) || (state_i == RESP);
            assign w_changed = (state_i != r_state_seen);
            assign w_cycles  = w_changed ? EXT_W'(1) : ({1'b0, r_count} + EXT_W'(1));
            assign expire_o  = w_active && (w_cycles >= C_LIMIT);

            // Track phase changes and count cycles, saturating at LIMIT.
            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    r_count      <= '0;
                    r_state_seen <= IDLE;
                end else begin
                    r_state_seen <= state_i;
                    if (!w_active) begin
                        r_count <= '0;
                    end else if (w_cycles >= C_LIMIT) begin
                        r_count <= C_LIMIT[CNT_W-1:0];
                    end else begin
                        r_count <= w_cycles[CNT_W-1:0];
                    end
                end
            end
        end else begin : g_disabled
            assign expire_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/obi_master.sv
`default_nettype none
// ============================================================================
//  Module      : obi_master
//  Description : OBI manager front-end. Accepts one command at a time from a
//                local controller, runs the A and R phases on the OBI bus and
//                holds the response until the controller takes it. A watchdog
//                aborts stalled phases and reports them as errors. Every
//                output is driven straight from a register.
//  Revision    : 1.0  initial release
// ============================================================================
module obi_master
    import obi_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                    clk_i,
    input  wire logic                    reset_ni,
    input  wire logic                    ctrl_valid_i,
    output logic                         ctrl_ready_o,
    input  wire logic                    ctrl_we_i,
    input  wire logic [ADDR_WIDTH-1:0]   ctrl_addr_i,
    input  wire logic [DATA_WIDTH-1:0]   ctrl_wdata_i,
    input  wire logic [DATA_WIDTH/8-1:0] ctrl_be_i,
    output logic                         ctrl_rvalid_o,
    input  wire logic                    ctrl_rready_i,
    output logic [DATA_WIDTH-1:0]        ctrl_rdata_o,
    output logic                         ctrl_err_o,
    obi_if.master                        obi
);

    localparam logic [DATA_WIDTH-1:0] C_TIMEOUT_RDATA = DATA_WIDTH'(TIMEOUT_RDATA);

    obi_mgr_state_e              r_state;
    logic                        r_ctrl_ready;
    logic                        r_ctrl_rvalid;
    logic [DATA_WIDTH-1:0]       r_ctrl_rdata;
    logic                        r_ctrl_err;
    logic                        r_req;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic                        r_we;
    logic [DATA_WIDTH/8-1:0]     r_be;
    logic [DATA_WIDTH-1:0]       r_wdata;
    logic                        r_rready;
    logic                        w_expire;

    obi_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .state_i  (r_state),
        .expire_o (w_expire)
    );

    assign ctrl_ready_o  = r_ctrl_ready;
    assign ctrl_rvalid_o = r_ctrl_rvalid;
    assign ctrl_rdata_o  = r_ctrl_rdata;
    assign ctrl_err_o    = r_ctrl_err;
    assign obi.req       = r_req;
    assign obi.addr      = r_addr;
    assign obi.we        = r_we;
    assign obi.be        = r_be;
    assign obi.wdata     = r_wdata;
    assign obi.rready    = r_rready;

    // Transaction FSM with registered bus and controller outputs.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= IDLE;
            r_ctrl_ready  <= 1'b0;
            r_ctrl_rvalid <= 1'b0;
            r_ctrl_rdata  <= '0;
            r_ctrl_err    <= 1'b0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_be          <= '0;
            r_wdata       <= '0;
            r_rready      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ctrl_ready <= 1'b1;
                    if (ctrl_valid_i && r_ctrl_ready) begin
                        r_ctrl_ready <= 1'b0;
                        r_addr       <= ctrl_addr_i;
                        r_we         <= ctrl_we_i;
                        r_be         <= ctrl_be_i;
                        r_wdata      <= ctrl_wdata_i;
                        r_req        <= 1'b1;
                        r_state      <= ADDR;
                    end
                end
                ADDR: begin
                    // A grant on the expiry edge still completes normally.
                    if (obi.gnt) begin
                        r_req    <= 1'b0;
                        r_rready <= 1'b1;
                        r_state  <= RESP;
                    end else if (w_expire) begin
                        // Request withdrawn without a grant: reported as an error.
                        r_req         <= 1'b0;
                        r_ctrl_rdata  <= C_TIMEOUT_RDATA;
                        r_ctrl_err    <= 1'b1;
                        r_ctrl_rvalid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                RESP: begin
                    if (obi.rvalid) begin
                        r_rready      <= 1'b0;
                        r_ctrl_rdata  <= obi.rdata;
                        r_ctrl_err    <= obi.err;
                        r_ctrl_rvalid <= 1'b1;
                        r_state       <= HOLD;
                    end else if (w_expire) begin
                        r_rready      <= 1'b0;
                        r_ctrl_rdata  <= C_TIMEOUT_RDATA;
                        r_ctrl_err    <= 1'b1;
                        r_ctrl_rvalid <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (ctrl_rready_i) begin
                        r_ctrl_rvalid <= 1'b0;
                        r_ctrl_ready  <= 1'b1;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obi_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obi_master
//  Description : Directed bench for obi_master against a behavioural
//                subordinate stub with programmable grant delay and an
//                option to withhold the response.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_obi_master;
    import obi_pkg::*;

    logic        clk;
    logic        reset_ni;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic        ctrl_we;
    logic [31:0] ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic [3:0]  ctrl_be;
    logic        ctrl_rvalid;
    logic        ctrl_rready;
    logic [31:0] ctrl_rdata;
    logic        ctrl_err;

    obi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    obi_master #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .ctrl_valid_i  (ctrl_valid),
        .ctrl_ready_o  (ctrl_ready),
        .ctrl_we_i     (ctrl_we),
        .ctrl_addr_i   (ctrl_addr),
        .ctrl_wdata_i  (ctrl_wdata),
        .ctrl_be_i     (ctrl_be),
        .ctrl_rvalid_o (ctrl_rvalid),
        .ctrl_rready_i (ctrl_rready),
        .ctrl_rdata_o  (ctrl_rdata),
        .ctrl_err_o    (ctrl_err),
        .obi           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- subordinate stub ----------------
    int          gnt_delay;
    bit          no_rvalid;
    int          wait_cnt;
    logic [31:0] mem [16];

    assign bus.gnt = bus.req && (wait_cnt >= gnt_delay);

    // Grant after gnt_delay waiting cycles, respond one cycle after the grant.
    always @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            wait_cnt   <= 0;
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
            bus.err    <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem[4] <= 32'hDA7A_5EAD;
        end else begin
            if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
            if (bus.req && !bus.gnt) wait_cnt <= wait_cnt + 1;
            else                     wait_cnt <= 0;
            if (bus.req && bus.gnt) begin
                if (bus.addr < 32'd16) begin
                    if (bus.we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.be[b]) mem[bus.addr[3:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
                        bus.rdata <= '0;
                    end else begin
                        bus.rdata <= mem[bus.addr[3:0]];
                    end
                    bus.err <= 1'b0;
                end else begin
                    bus.rdata <= BAD_RDATA;
                    bus.err   <= 1'b1;
                end
                if (!no_rvalid) bus.rvalid <= 1'b1;
            end
        end
    end

    // ---------------- scoreboard and checking ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          check_rdata;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  32'(ctrl_ready),  32'd0);
        check({tag, "_rvalid"}, 32'(ctrl_rvalid), 32'd0);
        check({tag, "_rdata"},  ctrl_rdata,       32'd0);
        check({tag, "_err"},    32'(ctrl_err),    32'd0);
        check({tag, "_req"},    32'(bus.req),     32'd0);
        check({tag, "_rready"}, 32'(bus.rready),  32'd0);
        check({tag, "_addr"},   bus.addr,         32'd0);
        check({tag, "_we"},     32'(bus.we),      32'd0);
    endtask

    // Wait for ready, present one command for one accepting edge, push expectation.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] exp_rdata,
                         input logic exp_err, input bit chk_rdata);
        int n;
        n = 0;
        while (!ctrl_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 32'(ctrl_ready), 32'd1);
        ctrl_valid = 1'b1;
        ctrl_we    = we;
        ctrl_addr  = addr;
        ctrl_wdata = wdata;
        ctrl_be    = be;
        sb.push_back('{rdata: exp_rdata, err: exp_err, check_rdata: chk_rdata});
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    // Wait for the response, compare against the scoreboard, hold, then release.
    task automatic collect(input string tag, input int hold_cycles, input int max_wait,
                           output int waited);
        exp_t        e;
        logic [31:0] held_rdata;
        logic        held_err;
        waited = 0;
        while (!ctrl_rvalid && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_rvalid"}, 32'(ctrl_rvalid), 32'd1);
        if (ctrl_rvalid && sb.size() > 0) begin
            e = sb.pop_front();
            if (e.check_rdata) check({tag, "_rdata"}, ctrl_rdata, e.rdata);
            check({tag, "_err"}, 32'(ctrl_err), 32'(e.err));
            held_rdata = ctrl_rdata;
            held_err   = ctrl_err;
            for (int i = 0; i < hold_cycles; i++) begin
                @(negedge clk);
                check({tag, "_hold_rvalid"}, 32'(ctrl_rvalid), 32'd1);
                check({tag, "_hold_rdata"},  ctrl_rdata,       held_rdata);
                check({tag, "_hold_err"},    32'(ctrl_err),    32'(held_err));
            end
            ctrl_rready = 1'b1;
            @(negedge clk);
            ctrl_rready = 1'b0;
            check({tag, "_release_rvalid"}, 32'(ctrl_rvalid), 32'd0);
            check({tag, "_release_ready"},  32'(ctrl_ready),  32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int waited;
        int a_cycles;
        int r_cycles;

        reset_ni    = 1'b0;
        ctrl_valid  = 1'b0;
        ctrl_we     = 1'b0;
        ctrl_addr   = '0;
        ctrl_wdata  = '0;
        ctrl_be     = '0;
        ctrl_rready = 1'b0;
        gnt_delay   = 0;
        no_rvalid   = 1'b0;

        // T0a: reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_ni = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 32'(ctrl_ready), 32'd1);

        // T0b: reset pulse in the middle of a stalled A phase
        gnt_delay = 5;
        issue(1'b0, 32'h4, 32'h0, 4'hF, 32'h0, 1'b0, 1'b0);
        check("t0_req_before_reset", 32'(bus.req), 32'd1);
        @(negedge clk);
        reset_ni = 1'b0;
        #1;
        check("t0_state_idle", 32'(dut.r_state), 32'(IDLE));
        check_all_zero("t0_midrun");
        sb.delete();
        gnt_delay = 0;
        @(negedge clk);
        reset_ni = 1'b1;
        @(negedge clk);
        check("t0_ready_after", 32'(ctrl_ready), 32'd1);

        // T1: read with immediate grant and response, best-case latency
        issue(1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'hDA7A_5EAD, 1'b0, 1'b1);
        collect("t1", 0, 10, waited);
        check("t1_latency", 32'(waited + 1), 32'd3);

        // T2: unmapped address returns the error pattern
        issue(1'b0, 32'hFFFF_FFFF, 32'h0, 4'hF, BAD_RDATA, 1'b1, 1'b1);
        collect("t2", 0, 10, waited);

        // T3: write then read back
        issue(1'b1, 32'h0000_0002, 32'h1337_C0DE, 4'hF, 32'h0, 1'b0, 1'b0);
        collect("t3w", 0, 10, waited);
        check("t3_mem2", mem[2], 32'h1337_C0DE);
        issue(1'b0, 32'h0000_0002, 32'h0, 4'hF, 32'h1337_C0DE, 1'b0, 1'b1);
        collect("t3r", 0, 10, waited);

        // T4: grant after three waiting cycles, then a slow controller
        gnt_delay = 3;
        issue(1'b1, 32'h0000_0007, 32'hCAFE_F00D, 4'hA, 32'h0, 1'b0, 1'b0);
        a_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            if (!bus.req) break;
            a_cycles++;
            check("t4_addr_stable",  bus.addr,      32'h0000_0007);
            check("t4_wdata_stable", bus.wdata,     32'hCAFE_F00D);
            check("t4_be_stable",    32'(bus.be),   32'hA);
            check("t4_we_stable",    32'(bus.we),   32'd1);
            @(negedge clk);
        end
        check("t4_a_cycles", 32'(a_cycles), 32'd4);
        collect("t4", 5, 10, waited);
        check("t4_mem7", mem[7], 32'hCA00_F000 | (32'h1000_0007 & 32'h00FF_00FF));
        gnt_delay = 0;

        // T5: response never arrives, watchdog aborts after 16 RESP cycles
        no_rvalid = 1'b1;
        issue(1'b0, 32'h0000_0004, 32'h0, 4'hF, TIMEOUT_RDATA, 1'b1, 1'b1);
        r_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (ctrl_rvalid) break;
            if (bus.rready) r_cycles++;
            @(negedge clk);
        end
        check("t5_resp_cycles", 32'(r_cycles), 32'd16);
        check("t5_rready_dropped", 32'(bus.rready), 32'd0);
        check("t5_req_low", 32'(bus.req), 32'd0);
        collect("t5", 2, 5, waited);
        no_rvalid = 1'b0;

        // Recovery after the abort
        issue(1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'hDA7A_5EAD, 1'b0, 1'b1);
        collect("t5_recover", 0, 10, waited);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
